// File: rtl/s_axi_lite_wr_engine_if.sv
// AXI4-Lite write channels plus the shared bank command port of the write engine.
// The slave modport is the engine side; the master modport is the host/bank side.
interface s_axi_lite_wr_engine_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BANK_SEL_WIDTH = 2,
  parameter int INDEX_WIDTH    = 8,
  parameter int FIELD_WIDTH    = 4
);
  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic                      wr_valid;
  logic                      wr_ready;
  logic                      wr_err;
  logic [BANK_SEL_WIDTH-1:0] wr_bank;
  logic [INDEX_WIDTH-1:0]    wr_index;
  logic [FIELD_WIDTH-1:0]    wr_field;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_strb;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output wr_valid, wr_bank, wr_index, wr_field, wr_data, wr_strb,
    input  wr_ready, wr_err
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  wr_valid, wr_bank, wr_index, wr_field, wr_data, wr_strb,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/s_axi_lite_wr_engine.sv
// AXI4-Lite write slave: collects AW/W in any order, decodes bank/index/field,
// issues one bank command per write and returns OKAY/SLVERR with an error counter.
module s_axi_lite_wr_engine #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BANK_SEL_WIDTH = 2,
  parameter int NUM_BANKS      = 2,
  parameter int INDEX_WIDTH    = 8,
  parameter int FIELD_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ERRCNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  s_axi_lite_wr_engine_if.slave   bus,
  output logic [ERRCNT_WIDTH-1:0] err_cnt
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [BANK_SEL_WIDTH:0] NUM_BANKS_V = NUM_BANKS[BANK_SEL_WIDTH:0];

  typedef enum logic [1:0] {COLLECT, ISSUE, RESP} state_t;

  state_t                  state_reg, state_next;
  logic                    aw_full_reg, w_full_reg;
  logic [ADDR_WIDTH-1:0]   awaddr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic [1:0]              bresp_reg, bresp_next;
  logic [TW-1:0]           to_cnt_reg, to_cnt_next;
  logic [ERRCNT_WIDTH-1:0] err_cnt_reg;
  logic                    err_inc;

  logic                      awready, wready, aw_fire, w_fire, pair_done, decode_err, issuing;
  logic [ADDR_WIDTH-1:0]     addr_mux;
  logic [STRB_WIDTH-1:0]     strb_mux;
  logic [BANK_SEL_WIDTH-1:0] bank_mux;

  assign awready = (state_reg == COLLECT) && !aw_full_reg;
  assign wready  = (state_reg == COLLECT) && !w_full_reg;
  assign aw_fire = bus.S_AXI_AWVALID && awready;
  assign w_fire  = bus.S_AXI_WVALID && wready;

  // Decode sees the value arriving this cycle, or the one already held.
  assign addr_mux   = aw_fire ? bus.S_AXI_AWADDR : awaddr_reg;
  assign strb_mux   = w_fire ? bus.S_AXI_WSTRB : wstrb_reg;
  assign bank_mux   = addr_mux[ADDR_WIDTH-1 -: BANK_SEL_WIDTH];
  assign decode_err = (addr_mux[1:0] != 2'b00) || ({1'b0, bank_mux} >= NUM_BANKS_V);
  assign pair_done  = (aw_fire || w_fire) && (aw_fire || aw_full_reg) && (w_fire || w_full_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= COLLECT;
      bresp_reg   <= 2'b00;
      to_cnt_reg  <= '0;
      err_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      bresp_reg  <= bresp_next;
      to_cnt_reg <= to_cnt_next;
      if (err_inc && (err_cnt_reg != {ERRCNT_WIDTH{1'b1}}))
        err_cnt_reg <= err_cnt_reg + ERRCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else if ((state_reg == RESP) && bus.S_AXI_BREADY) begin
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      if (aw_fire) begin
        aw_full_reg <= 1'b1;
        awaddr_reg  <= bus.S_AXI_AWADDR;
      end
      if (w_fire) begin
        w_full_reg <= 1'b1;
        wdata_reg  <= bus.S_AXI_WDATA;
        wstrb_reg  <= bus.S_AXI_WSTRB;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    bresp_next  = bresp_reg;
    to_cnt_next = to_cnt_reg;
    err_inc     = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (pair_done) begin
          if (decode_err) begin
            state_next = RESP;
            bresp_next = 2'b10;
            err_inc    = 1'b1;
          end else if (strb_mux == '0) begin
            state_next = RESP;
            bresp_next = 2'b00;
          end else begin
            state_next  = ISSUE;
            to_cnt_next = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.wr_ready) begin
          state_next = RESP;
          bresp_next = bus.wr_err ? 2'b10 : 2'b00;
          err_inc    = bus.wr_err;
        end else if (TIMEOUT_EN && (to_cnt_reg == TO_LAST)) begin
          state_next = RESP;
          bresp_next = 2'b10;
          err_inc    = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
        end
      end
      RESP: begin
        if (bus.S_AXI_BREADY) begin
          state_next = COLLECT;
          bresp_next = 2'b00;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Command fields are forced to zero whenever no command is being offered.
  assign issuing           = (state_reg == ISSUE);
  assign bus.wr_valid      = issuing;
  assign bus.wr_bank       = issuing ? awaddr_reg[ADDR_WIDTH-1 -: BANK_SEL_WIDTH] : '0;
  assign bus.wr_index      = issuing ? awaddr_reg[6 +: INDEX_WIDTH] : '0;
  assign bus.wr_field      = issuing ? awaddr_reg[5:2] : '0;
  assign bus.wr_data       = issuing ? wdata_reg : '0;
  assign bus.wr_strb       = issuing ? wstrb_reg : '0;
  assign bus.S_AXI_AWREADY = awready;
  assign bus.S_AXI_WREADY  = wready;
  assign bus.S_AXI_BVALID  = (state_reg == RESP);
  assign bus.S_AXI_BRESP   = bresp_reg;
  assign err_cnt           = err_cnt_reg;
endmodule

// File: tb/tb_s_axi_lite_wr_engine.sv
// Directed bench for s_axi_lite_wr_engine: one task per scenario, inline checks,
// one line printed per completed write transaction.
module tb_s_axi_lite_wr_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] err_cnt;
  int          total = 0;
  int          bad = 0;

  s_axi_lite_wr_engine_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BANK_SEL_WIDTH(2),
                            .INDEX_WIDTH(8), .FIELD_WIDTH(4)) bus ();

  s_axi_lite_wr_engine #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BANK_SEL_WIDTH(2), .NUM_BANKS(2),
                         .INDEX_WIDTH(8), .FIELD_WIDTH(4), .TIMEOUT_CYCLES(64),
                         .ERRCNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_both(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  task automatic finish_b(input string name);
    $display("txn %s: bresp=%b err_cnt=%0d", name, bus.S_AXI_BRESP, err_cnt);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    total++;
    if (bus.S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL %s_bvalid_clear got=%b exp=0", name, bus.S_AXI_BVALID); end
  endtask

  task automatic test_reset();
    total++;
    if (bus.S_AXI_BVALID !== 1'b0 || bus.wr_valid !== 1'b0 || bus.S_AXI_BRESP !== 2'b00 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_outputs got bvalid=%b wr_valid=%b bresp=%b err=%0d exp 0/0/00/0",
                      bus.S_AXI_BVALID, bus.wr_valid, bus.S_AXI_BRESP, err_cnt);
    end
    total++;
    if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_WREADY !== 1'b1) begin
      bad++; $display("FAIL reset_ready got aw=%b w=%b exp 1/1", bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
    end
  endtask

  task automatic test_same_cycle();
    bus.wr_ready = 1'b1;
    drive_both(16'h4008, 32'hDEADBEEF, 4'hF);
    total++;
    if ({bus.wr_valid, bus.wr_bank, bus.wr_index, bus.wr_field, bus.wr_data, bus.wr_strb} !==
        {1'b1, 2'd1, 8'd0, 4'd2, 32'hDEADBEEF, 4'hF}) begin
      bad++; $display("FAIL t1_cmd got v=%b b=%0d i=%0d f=%0d d=%h s=%h exp 1/1/0/2/deadbeef/f",
                      bus.wr_valid, bus.wr_bank, bus.wr_index, bus.wr_field, bus.wr_data, bus.wr_strb);
    end
    tick();
    total++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00 || bus.wr_valid !== 1'b0) begin
      bad++; $display("FAIL t1_resp got bvalid=%b bresp=%b wr_valid=%b exp 1/00/0",
                      bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.wr_valid);
    end
    bus.wr_ready = 1'b0;
    finish_b("t1");
  endtask

  task automatic test_w_first();
    int issued = 0;
    bus.S_AXI_WDATA  = 32'h11223344;
    bus.S_AXI_WSTRB  = 4'h3;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    total++;
    if (bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1) begin
      bad++; $display("FAIL t2_wready got w=%b aw=%b exp 0/1", bus.S_AXI_WREADY, bus.S_AXI_AWREADY);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.wr_valid === 1'b1) issued++;
    end
    bus.S_AXI_AWADDR  = 16'h0100;
    bus.S_AXI_AWVALID = 1'b1;
    bus.wr_ready      = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    total++;
    if ({bus.wr_valid, bus.wr_bank, bus.wr_index, bus.wr_data, bus.wr_strb} !== {1'b1, 2'd0, 8'd4, 32'h11223344, 4'h3}) begin
      bad++; $display("FAIL t2_cmd got v=%b b=%0d i=%0d d=%h s=%h exp 1/0/4/11223344/3",
                      bus.wr_valid, bus.wr_bank, bus.wr_index, bus.wr_data, bus.wr_strb);
    end
    if (bus.wr_valid === 1'b1) issued++;
    tick();
    if (bus.wr_valid === 1'b1) issued++;
    bus.wr_ready = 1'b0;
    total++;
    if (issued !== 1 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
      bad++; $display("FAIL t2_once got issued=%0d bvalid=%b bresp=%b exp 1/1/00", issued, bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
    finish_b("t2");
  endtask

  task automatic test_decode_err();
    drive_both(16'h8000, 32'h0, 4'hF);
    total++;
    if (bus.wr_valid !== 1'b0 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b10 || err_cnt !== 16'd1) begin
      bad++; $display("FAIL t3_bank got v=%b bvalid=%b bresp=%b err=%0d exp 0/1/10/1",
                      bus.wr_valid, bus.S_AXI_BVALID, bus.S_AXI_BRESP, err_cnt);
    end
    finish_b("t3a");
    drive_both(16'h4001, 32'h5, 4'h1);
    total++;
    if (bus.wr_valid !== 1'b0 || bus.S_AXI_BRESP !== 2'b10 || err_cnt !== 16'd2) begin
      bad++; $display("FAIL t3_misalign got v=%b bresp=%b err=%0d exp 0/10/2", bus.wr_valid, bus.S_AXI_BRESP, err_cnt);
    end
    finish_b("t3b");
  endtask

  task automatic test_timeout();
    int high = 0;
    bus.wr_ready = 1'b0;
    drive_both(16'h4010, 32'hCAFE0001, 4'hF);
    for (int i = 0; i < 100 && bus.S_AXI_BVALID !== 1'b1; i++) begin
      if (bus.wr_valid === 1'b1) high++;
      tick();
    end
    total++;
    if (high !== 64 || bus.wr_valid !== 1'b0 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b10) begin
      bad++; $display("FAIL t4_timeout got high=%0d v=%b bvalid=%b bresp=%b exp 64/0/1/10",
                      high, bus.wr_valid, bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
    total++;
    if (err_cnt !== 16'd3) begin bad++; $display("FAIL t4_errcnt got=%0d exp=3", err_cnt); end
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    total++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b10 || err_cnt !== 16'd3) begin
      bad++; $display("FAIL t4_late_ready got bvalid=%b bresp=%b err=%0d exp 1/10/3", bus.S_AXI_BVALID, bus.S_AXI_BRESP, err_cnt);
    end
    finish_b("t4");
    bus.wr_ready = 1'b1;
    tick();
    tick();
    bus.wr_ready = 1'b0;
    total++;
    if (bus.S_AXI_BVALID !== 1'b0 || bus.wr_valid !== 1'b0) begin
      bad++; $display("FAIL t4_no_extra got bvalid=%b v=%b exp 0/0", bus.S_AXI_BVALID, bus.wr_valid);
    end
  endtask

  task automatic test_bank_err_stall();
    int unstable = 0;
    bus.wr_ready = 1'b1;
    bus.wr_err   = 1'b1;
    drive_both(16'h4004, 32'h0000ABCD, 4'hF);
    tick();
    bus.wr_ready = 1'b0;
    bus.wr_err   = 1'b0;
    bus.S_AXI_AWADDR  = 16'h4020;
    bus.S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b10 || bus.S_AXI_AWREADY !== 1'b0) unstable++;
      tick();
    end
    bus.S_AXI_AWVALID = 1'b0;
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL t5_stall got unstable_cycles=%0d exp=0", unstable); end
    total++;
    if (err_cnt !== 16'd4 || bus.S_AXI_BRESP !== 2'b10) begin
      bad++; $display("FAIL t5_errcnt got err=%0d bresp=%b exp 4/10", err_cnt, bus.S_AXI_BRESP);
    end
    finish_b("t5");
    total++;
    if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_WREADY !== 1'b1) begin
      bad++; $display("FAIL t5_held_aw_ignored got aw=%b w=%b exp 1/1", bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
    end
  endtask

  task automatic test_strb0_and_reset();
    drive_both(16'h4000, 32'h12345678, 4'h0);
    total++;
    if (bus.wr_valid !== 1'b0 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00 || err_cnt !== 16'd4) begin
      bad++; $display("FAIL t6_strb0 got v=%b bvalid=%b bresp=%b err=%0d exp 0/1/00/4",
                      bus.wr_valid, bus.S_AXI_BVALID, bus.S_AXI_BRESP, err_cnt);
    end
    finish_b("t6a");
    drive_both(16'h40C4, 32'h0F0F0F0F, 4'hC);
    total++;
    if (bus.wr_valid !== 1'b1) begin bad++; $display("FAIL t6_issue got v=%b exp=1", bus.wr_valid); end
    reset = 1'b1;
    #1;
    total++;
    if (bus.wr_valid !== 1'b0 || bus.wr_data !== 32'h0 || bus.S_AXI_BVALID !== 1'b0 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL t6_reset got v=%b d=%h bvalid=%b err=%0d exp 0/0/0/0",
                      bus.wr_valid, bus.wr_data, bus.S_AXI_BVALID, err_cnt);
    end
    tick();
    reset = 1'b0;
    tick();
    bus.wr_ready = 1'b1;
    drive_both(16'h40C4, 32'h0F0F0F0F, 4'hC);
    total++;
    if ({bus.wr_valid, bus.wr_bank, bus.wr_index, bus.wr_field, bus.wr_strb} !== {1'b1, 2'd1, 8'd3, 4'd1, 4'hC}) begin
      bad++; $display("FAIL t6_after_reset_cmd got v=%b b=%0d i=%0d f=%0d s=%h exp 1/1/3/1/c",
                      bus.wr_valid, bus.wr_bank, bus.wr_index, bus.wr_field, bus.wr_strb);
    end
    tick();
    bus.wr_ready = 1'b0;
    total++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
      bad++; $display("FAIL t6_after_reset_resp got bvalid=%b bresp=%b exp 1/00", bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
    finish_b("t6b");
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0; bus.wr_ready = 1'b0; bus.wr_err = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_decode_err();
    test_timeout();
    test_bank_err_stall();
    test_strb0_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
